// File: rtl/result_writeback_if.sv
// result_writeback_if: bundles the result-capture handshake and the host read port
// of result_writeback.
//   master: block producer / host side (drives start, res_valid, res_data, out_enb,
//           out_addrb; observes busy, done, drop_err, blk_count, out_doutb, out_valid)
//   slave : result_writeback side (the reverse)
// WIDTH, CHUNK_SIZE and ADDR_W must match the parameters of the attached writer.
interface result_writeback_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHUNK_SIZE = 4,
  parameter int unsigned ADDR_W     = 4
);
  logic                          start;
  logic                          res_valid;
  logic [WIDTH*CHUNK_SIZE-1:0]   res_data;
  logic                          busy;
  logic                          done;
  logic                          drop_err;
  logic [ADDR_W:0]               blk_count;
  logic                          out_enb;
  logic [ADDR_W-1:0]             out_addrb;
  logic [WIDTH*CHUNK_SIZE-1:0]   out_doutb;
  logic                          out_valid;

  modport master (
    output start, res_valid, res_data, out_enb, out_addrb,
    input  busy, done, drop_err, blk_count, out_doutb, out_valid
  );

  modport slave (
    input  start, res_valid, res_data, out_enb, out_addrb,
    output busy, done, drop_err, blk_count, out_doutb, out_valid
  );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: output-side writer of the matrix-multiply datapath.
// Captures each finished output block (res_data qualified by the res_valid pulse)
// while collecting, stores it row-major by C-block coordinate in an internal memory
// of MAX_FLAG words, and serves a synchronous, read-first host read port.
// Ports:
//   clk, rst_n : clock (posedge) and asynchronous active-low reset
//   bus.slave  : start / res_valid / res_data capture side, busy / done / drop_err /
//                blk_count status, out_enb / out_addrb / out_doutb / out_valid reads
// Build option:
//   OUT_RELU_EN : when defined, every WIDTH-bit signed element with its MSB set is
//                 stored as zero; otherwise blocks are stored bit-exact.
module result_writeback #(
  parameter int unsigned WIDTH             = 16,
  parameter int unsigned CHUNK_SIZE        = 4,
  parameter int unsigned BLOCK_SIZE        = 2,
  parameter int unsigned I_OUTER_DIMENSION = 6,
  parameter int unsigned W_OUTER_DIMENSION = 6
) (
  input logic                clk,
  input logic                rst_n,
  result_writeback_if.slave  bus
);

  localparam int unsigned ROW_SIZE_MAT_C = I_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int unsigned COL_SIZE_MAT_C = W_OUTER_DIMENSION / BLOCK_SIZE;
  localparam int unsigned MAX_FLAG       = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
  localparam int unsigned ADDR_W         = (MAX_FLAG > 1) ? $clog2(MAX_FLAG) : 1;
  localparam int unsigned DW             = WIDTH * CHUNK_SIZE;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W:0]   blk_count_q, blk_count_d;
  logic              drop_err_q, drop_err_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DW-1:0]     wr_data;

  logic [DW-1:0]     mem [MAX_FLAG];
  logic [DW-1:0]     out_doutb_q;
  logic              out_valid_q;
  logic              rd_in_range;

  // Row-major placement: the block at (row, col) lands at row*COL_SIZE_MAT_C+col.
  assign wr_addr = row_q * ADDR_W'(COL_SIZE_MAT_C) + col_q;

`ifdef OUT_RELU_EN
  // Each element is clamped on its own sign bit; negatives become zero.
  always_comb begin
    wr_data = bus.res_data;
    for (int i = 0; i < int'(CHUNK_SIZE); i++) begin
      if (bus.res_data[i*WIDTH + WIDTH - 1]) begin
        wr_data[i*WIDTH +: WIDTH] = '0;
      end
    end
  end
`else
  assign wr_data = bus.res_data;
`endif

  // Next-state logic. start wins over res_valid in the same cycle: the block is
  // discarded silently and is not counted as a drop.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    blk_count_d = blk_count_q;
    drop_err_d  = drop_err_q;
    wr_en       = 1'b0;

    if (bus.start) begin
      state_d     = StCollect;
      row_d       = '0;
      col_d       = '0;
      blk_count_d = '0;
      drop_err_d  = 1'b0;
    end else if (bus.res_valid) begin
      unique case (state_q)
        StCollect: begin
          wr_en       = 1'b1;
          blk_count_d = blk_count_q + (ADDR_W+1)'(1);
          if (col_q == ADDR_W'(COL_SIZE_MAT_C - 1)) begin
            col_d = '0;
            row_d = row_q + ADDR_W'(1);
          end else begin
            col_d = col_q + ADDR_W'(1);
          end
          if (blk_count_q == (ADDR_W+1)'(MAX_FLAG - 1)) begin
            state_d = StDone;
          end
        end
        StIdle, StDone: begin
          drop_err_d = 1'b1;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      blk_count_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      blk_count_q <= blk_count_d;
      drop_err_q  <= drop_err_d;
    end
  end

  // Storage is deliberately not reset so a reset mid-collection keeps the
  // partially written matrix.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_in_range = (32'(bus.out_addrb) < MAX_FLAG);

  // Read port samples the array before this cycle's write lands (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_doutb_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.out_enb;
      if (bus.out_enb) begin
        out_doutb_q <= rd_in_range ? mem[bus.out_addrb] : '0;
      end
    end
  end

  assign bus.busy      = (state_q == StCollect);
  assign bus.done      = (state_q == StDone);
  assign bus.drop_err  = drop_err_q;
  assign bus.blk_count = blk_count_q;
  assign bus.out_doutb = out_doutb_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_result_writeback.sv
// Testbench for result_writeback: directed scenarios plus a randomized run, all
// checked against a block-level model (sequential store index, sticky flags).
module tb_result_writeback;
  localparam int NBLK = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  result_writeback_if #(.WIDTH(16), .CHUNK_SIZE(4), .ADDR_W(4)) bus ();

  result_writeback #(
    .WIDTH(16), .CHUNK_SIZE(4), .BLOCK_SIZE(2),
    .I_OUTER_DIMENSION(6), .W_OUTER_DIMENSION(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: blocks arrive in row-major order, so the n-th stored block
  // of a matrix simply lives at address n.
  logic [63:0] m_mem [NBLK];
  bit          m_busy, m_done, m_drop, m_rvalid;
  int          m_cnt;
  logic [63:0] m_rdata;

  function automatic logic [63:0] m_store(input logic [63:0] w);
    logic [63:0] r;
    r = w;
`ifdef OUT_RELU_EN
    for (int e = 0; e < 4; e++) begin
      if ($signed(w[e*16 +: 16]) < 0) r[e*16 +: 16] = 16'h0;
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_drop = 0; m_rvalid = 0; m_cnt = 0; m_rdata = '0;
  endtask

  task automatic drive(input bit st, input bit rv, input logic [63:0] d,
                       input bit en, input logic [3:0] a);
    bus.start = st; bus.res_valid = rv; bus.res_data = d;
    bus.out_enb = en; bus.out_addrb = a;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, '0);
  endtask

  // One clock: capture inputs, pass the posedge, update the model, end at negedge.
  task automatic tick();
    bit st, rv, en;
    logic [63:0] d;
    logic [3:0] a;
    st = bus.start; rv = bus.res_valid; d = bus.res_data;
    en = bus.out_enb; a = bus.out_addrb;
    @(negedge clk);
    if (en) begin
      m_rdata  = (int'(a) < NBLK) ? m_mem[a] : 64'h0;
      m_rvalid = 1;
    end else begin
      m_rvalid = 0;
    end
    if (st) begin
      m_busy = 1; m_done = 0; m_cnt = 0; m_drop = 0;
    end else if (rv) begin
      if (m_busy) begin
        m_mem[m_cnt] = m_store(d);
        m_cnt++;
        if (m_cnt == NBLK) begin m_busy = 0; m_done = 1; end
      end else begin
        m_drop = 1;
      end
    end
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", bus.drop_err); end
    total++; if (bus.blk_count !== 5'd0) begin bad++; $display("FAIL reset_blk got=%0d want=0", bus.blk_count); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_oval got=%b want=0", bus.out_valid); end
    total++; if (bus.out_doutb !== 64'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", bus.out_doutb); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_collect();
    logic [63:0] prev;
    drive(1, 0, '0, 0, '0); tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL collect_busy got=%b want=1", bus.busy); end
    for (int k = 0; k < NBLK; k++) begin
      drive(0, 1, 64'h0001_0002_0003_0000 + 64'(k), 0, '0); tick();
      total++;
      if (bus.blk_count !== 5'(m_cnt) || bus.done !== m_done || bus.busy !== m_busy) begin
        bad++;
        $display("FAIL collect_blk%0d got cnt=%0d done=%b busy=%b want cnt=%0d done=%b busy=%b",
                 k, bus.blk_count, bus.done, bus.busy, m_cnt, m_done, m_busy);
      end
    end
    idle();
    total++; if (bus.done !== 1'b1 || bus.blk_count !== 5'd9) begin bad++;
      $display("FAIL collect_done got done=%b cnt=%0d want done=1 cnt=9", bus.done, bus.blk_count); end
    for (int k = 0; k < NBLK; k++) begin
      drive(0, 0, '0, 1, 4'(k)); tick();
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_doutb !== 64'h0001_0002_0003_0000 + 64'(k)) begin
        bad++;
        $display("FAIL collect_read%0d got v=%b d=%h want v=1 d=%h", k, bus.out_valid,
                 bus.out_doutb, 64'h0001_0002_0003_0000 + 64'(k));
      end
    end
    prev = m_rdata;
    idle(); tick();
    total++; if (bus.out_valid !== 1'b0 || bus.out_doutb !== prev) begin bad++;
      $display("FAIL read_hold got v=%b d=%h want v=0 d=%h", bus.out_valid, bus.out_doutb, prev); end
  endtask

  task automatic test_drop();
    apply_reset();
    drive(0, 1, 64'hDEAD_BEEF_0BAD_F00D, 0, '0); tick();
    idle();
    total++; if (bus.drop_err !== 1'b1 || bus.blk_count !== 5'd0 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL drop_flag got drop=%b cnt=%0d busy=%b want 1 0 0", bus.drop_err, bus.blk_count, bus.busy); end
    drive(0, 0, '0, 1, 4'd0); tick();
    total++; if (bus.out_doutb !== m_rdata) begin bad++;
      $display("FAIL drop_mem got=%h want=%h", bus.out_doutb, m_rdata); end
    drive(1, 0, '0, 0, '0); tick(); idle();
    total++; if (bus.drop_err !== 1'b0 || bus.busy !== 1'b1) begin bad++;
      $display("FAIL drop_clear got drop=%b busy=%b want 0 1", bus.drop_err, bus.busy); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, {$urandom, $urandom}, 0, '0); tick();
    end
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.busy !== 1'b0 || bus.blk_count !== 5'd0 || bus.out_valid !== 1'b0) begin bad++;
      $display("FAIL midreset got busy=%b cnt=%0d v=%b want 0 0 0", bus.busy, bus.blk_count, bus.out_valid); end
    @(negedge clk); rst_n = 1'b1;
    drive(1, 0, '0, 0, '0); tick();
    for (int k = 0; k < NBLK; k++) begin
      drive(0, 1, {$urandom, $urandom}, 0, '0); tick();
    end
    idle();
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL midreset_done got=%b want=1", bus.done); end
    for (int k = 0; k < NBLK; k++) begin
      drive(0, 0, '0, 1, 4'(k)); tick();
      total++; if (bus.out_doutb !== m_rdata || bus.out_valid !== 1'b1) begin bad++;
        $display("FAIL midreset_read%0d got v=%b d=%h want v=1 d=%h", k, bus.out_valid, bus.out_doutb, m_rdata); end
    end
    idle();
  endtask

  task automatic test_read_edges();
    logic [63:0] old2, new2;
    drive(0, 0, '0, 1, 4'd9); tick();
    total++; if (bus.out_doutb !== 64'h0 || bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL oor_read9 got v=%b d=%h want v=1 d=0", bus.out_valid, bus.out_doutb); end
    drive(0, 0, '0, 1, 4'd15); tick();
    total++; if (bus.out_doutb !== 64'h0) begin bad++;
      $display("FAIL oor_read15 got=%h want=0", bus.out_doutb); end
    old2 = m_mem[2];
    drive(1, 0, '0, 0, '0); tick();
    drive(0, 1, {$urandom, $urandom}, 0, '0); tick();
    drive(0, 1, {$urandom, $urandom}, 0, '0); tick();
    new2 = {$urandom, $urandom};
    drive(0, 1, new2, 1, 4'd2); tick();
    total++; if (bus.out_doutb !== old2) begin bad++;
      $display("FAIL read_first got=%h want=%h", bus.out_doutb, old2); end
    drive(0, 0, '0, 1, 4'd2); tick();
    total++; if (bus.out_doutb !== m_store(new2)) begin bad++;
      $display("FAIL read_after_write got=%h want=%h", bus.out_doutb, m_store(new2)); end
    idle();
  endtask

  task automatic test_relu();
    logic [63:0] w, exp_w;
    w = 64'hFF80_0040_8000_7FFF;
`ifdef OUT_RELU_EN
    exp_w = 64'h0000_0040_0000_7FFF;
`else
    exp_w = w;
`endif
    drive(1, 0, '0, 0, '0); tick();
    drive(0, 1, w, 0, '0); tick();
    drive(0, 0, '0, 1, 4'd0); tick();
    total++; if (bus.out_doutb !== exp_w) begin bad++;
      $display("FAIL relu_word got=%h want=%h", bus.out_doutb, exp_w); end
    idle();
  endtask

  task automatic test_start_override();
    drive(0, 1, {$urandom, $urandom}, 0, '0); tick();
    drive(1, 1, 64'h1234_5678_9ABC_DEF0, 0, '0); tick();
    idle();
    total++; if (bus.blk_count !== 5'd0 || bus.drop_err !== 1'b0 || bus.busy !== 1'b1) begin bad++;
      $display("FAIL start_override got cnt=%0d drop=%b busy=%b want 0 0 1",
               bus.blk_count, bus.drop_err, bus.busy); end
    drive(0, 0, '0, 1, 4'd2); tick();
    total++; if (bus.out_doutb !== m_rdata) begin bad++;
      $display("FAIL start_override_mem got=%h want=%h", bus.out_doutb, m_rdata); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 29) == 0), $urandom_range(0, 1), {$urandom, $urandom},
            $urandom_range(0, 1), 4'($urandom_range(0, 15)));
      tick();
      total++;
      if (bus.busy !== m_busy || bus.done !== m_done || bus.drop_err !== m_drop ||
          bus.blk_count !== 5'(m_cnt) || bus.out_valid !== m_rvalid || bus.out_doutb !== m_rdata) begin
        bad++;
        $display("FAIL random_cyc%0d got b=%b d=%b e=%b c=%0d v=%b q=%h want b=%b d=%b e=%b c=%0d v=%b q=%h",
                 i, bus.busy, bus.done, bus.drop_err, bus.blk_count, bus.out_valid, bus.out_doutb,
                 m_busy, m_done, m_drop, m_cnt, m_rvalid, m_rdata);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_collect();
    test_drop();
    test_reset_mid();
    test_read_edges();
    test_relu();
    test_start_override();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
